// File: rtl/sb_pkg.sv
// Shared types and widths for the sb burst master and its watchdog.
// Pure declarations: no logic, no latency, no flow control.
// Holds the master state enum and the bus field widths.
package sb_pkg;
    localparam int SB_DATA_W  = 32;
    localparam int SB_BURST_W = 8;
    localparam int SB_BE_W    = 4;
    // One extra bit so a 256-beat burst counts to 256 without wrapping.
    localparam int SB_CNT_W   = SB_BURST_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQUEST,
        S_ADDRESS,
        S_WRITE,
        S_WEND,
        S_READ,
        S_FINISH
    } sb_state_e;
endpackage

// File: rtl/sb_watchdog.sv
// Slave-response watchdog: counts idle cycles while run is high, cleared by kick.
// Latency: expired is combinational in the cycle the count reaches TIMEOUT_CYCLES.
// Backpressure: none; it only observes and flags.
module sb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic run,
    input  logic kick,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;

    // The cycle holding TIMEOUT_CYCLES-1 is the last one tolerated, so the
    // abort lands exactly TIMEOUT_CYCLES cycles after counting started.
    assign expired = run && !kick && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!run || kick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/sb_burst_master.sv
// Burst master on a wired-OR shared bus; watchdog built only with SB_BURST_MASTER_TIMEOUT_EN.
// Latency: command to REQUEST 1 cycle, read data passes through combinationally.
// Backpressure: wr_ready_o follows !sb_busy_i; the read stream cannot be stalled.
module sb_burst_master
    import sb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  sb_clock_i,
    input  logic                  sb_reset_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [SB_DATA_W-1:0]  cmd_addr_i,
    input  logic                  cmd_rnw_i,
    input  logic [SB_BURST_W-1:0] cmd_len_i,
    input  logic [SB_DATA_W-1:0]  wr_data_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    output logic [SB_DATA_W-1:0]  rd_data_o,
    output logic                  rd_valid_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  sb_request_o,
    input  logic                  sb_grant_i,
    output logic                  sb_begin_transaction_o,
    output logic                  sb_end_transaction_o,
    output logic                  sb_data_valid_o,
    output logic                  sb_read_n_write_o,
    output logic [SB_DATA_W-1:0]  sb_address_data_o,
    output logic [SB_BE_W-1:0]    sb_byte_enables_o,
    output logic [SB_BURST_W-1:0] sb_burst_size_o,
    input  logic [SB_DATA_W-1:0]  sb_address_data_i,
    input  logic                  sb_end_transaction_i,
    input  logic                  sb_data_valid_i,
    input  logic                  sb_busy_i,
    input  logic                  sb_error_i
);
    sb_state_e             state_q, state_d;
    logic [SB_DATA_W-1:0]  addr_q;
    logic                  rnw_q;
    logic [SB_BURST_W-1:0] len_q;
    logic [SB_CNT_W-1:0]   beat_q, beat_d;
    logic [SB_CNT_W-1:0]   rd_total;
    logic                  err_q, err_d;
    logic                  cmd_take, wr_beat, rd_beat, rd_short, wdog_expired;

    assign cmd_take = (state_q == S_IDLE) && cmd_valid_i;
    assign wr_beat  = (state_q == S_WRITE) && wr_valid_i && !sb_busy_i;
    // Beats past the requested length are still seen on the bus but dropped here.
    assign rd_beat  = (state_q == S_READ) && sb_data_valid_i && (beat_q <= {1'b0, len_q});
    assign rd_total = beat_q + SB_CNT_W'(rd_beat);
    assign rd_short = rd_total <= {1'b0, len_q};

`ifdef SB_BURST_MASTER_TIMEOUT_EN
    logic wdog_run, wdog_kick;

    assign wdog_run  = (state_q == S_REQUEST) || (state_q == S_WRITE) || (state_q == S_READ);
    assign wdog_kick = sb_grant_i || sb_data_valid_i || sb_end_transaction_i || wr_beat;

    sb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .sys_clk (sb_clock_i),
        .rst_n   (sb_reset_n_i),
        .run     (wdog_run),
        .kick    (wdog_kick),
        .expired (wdog_expired)
    );
`else
    assign wdog_expired = 1'b0;
`endif

    always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
        if (!sb_reset_n_i) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            rnw_q   <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            if (cmd_take) begin
                addr_q <= cmd_addr_i;
                rnw_q  <= cmd_rnw_i;
                len_q  <= cmd_len_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    state_d = S_REQUEST;
                    err_d   = 1'b0;
                end
            end
            S_REQUEST: begin
                if (sb_grant_i) begin
                    state_d = S_ADDRESS;
                end else if (wdog_expired) begin
                    state_d = S_FINISH;
                    err_d   = 1'b1;
                end
            end
            S_ADDRESS: begin
                beat_d = '0;
                if (sb_error_i) begin
                    state_d = S_FINISH;
                    err_d   = 1'b1;
                end else begin
                    state_d = rnw_q ? S_READ : S_WRITE;
                end
            end
            S_WRITE: begin
                if (sb_error_i || wdog_expired) begin
                    state_d = S_FINISH;
                    err_d   = 1'b1;
                end else if (wr_beat) begin
                    beat_d = beat_q + SB_CNT_W'(1);
                    if (beat_q == {1'b0, len_q}) begin
                        state_d = S_WEND;
                    end
                end
            end
            S_WEND: begin
                state_d = S_FINISH;
                if (sb_error_i) begin
                    err_d = 1'b1;
                end
            end
            S_READ: begin
                if (rd_beat) begin
                    beat_d = rd_total;
                end
                if (sb_error_i || (wdog_expired && !sb_end_transaction_i)) begin
                    state_d = S_FINISH;
                    err_d   = 1'b1;
                end else if (sb_end_transaction_i) begin
                    state_d = S_FINISH;
                    err_d   = rd_short;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Every bus output idles at zero so the wired-OR bus sees only the owner.
    always_comb begin
        cmd_ready_o            = 1'b0;
        wr_ready_o             = 1'b0;
        rd_data_o              = '0;
        rd_valid_o             = 1'b0;
        done_o                 = 1'b0;
        err_o                  = 1'b0;
        sb_request_o           = 1'b0;
        sb_begin_transaction_o = 1'b0;
        sb_end_transaction_o   = 1'b0;
        sb_data_valid_o        = 1'b0;
        sb_read_n_write_o      = 1'b0;
        sb_address_data_o      = '0;
        sb_byte_enables_o      = '0;
        sb_burst_size_o        = '0;
        case (state_q)
            S_IDLE: begin
                cmd_ready_o = sb_reset_n_i;
            end
            S_REQUEST: begin
                sb_request_o = 1'b1;
            end
            S_ADDRESS: begin
                sb_request_o           = 1'b1;
                sb_begin_transaction_o = 1'b1;
                sb_address_data_o      = addr_q;
                sb_burst_size_o        = len_q;
                sb_read_n_write_o      = rnw_q;
                sb_byte_enables_o      = '1;
            end
            S_WRITE: begin
                sb_request_o      = 1'b1;
                wr_ready_o        = !sb_busy_i;
                sb_data_valid_o   = wr_beat;
                sb_address_data_o = wr_beat ? wr_data_i : '0;
            end
            S_WEND: begin
                sb_request_o         = 1'b1;
                sb_end_transaction_o = !sb_error_i;
            end
            S_READ: begin
                sb_request_o = 1'b1;
                rd_valid_o   = rd_beat;
                rd_data_o    = rd_beat ? sb_address_data_i : '0;
            end
            S_FINISH: begin
                done_o = 1'b1;
                err_o  = err_q;
            end
            default: begin
                cmd_ready_o = 1'b0;
            end
        endcase
    end
endmodule

// File: doc/sb_burst_master.md
SB_BURST_MASTER -- requirements
Module: sb_burst_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, sets the slave-response watchdog limit in clock cycles when the watchdog is compiled in.
REQ-002 sb_clock_i  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 sb_reset_n_i  in  1  asynchronous, active-low reset.
REQ-004 cmd_valid_i / cmd_ready_o  in/out  1/1  client command handshake.
REQ-005 cmd_addr_i  in  32  start address; cmd_rnw_i  in  1  1=read, 0=write; cmd_len_i  in  8  beats minus one.
REQ-006 wr_data_i  in  32, wr_valid_i  in  1, wr_ready_o  out  1  write-data stream.
REQ-007 rd_data_o  out  32, rd_valid_o  out  1  read-data stream, no backpressure.
REQ-008 done_o  out  1  one-cycle completion pulse; err_o  out  1  qualifies done_o as failed.
REQ-009 sb_request_o  out  1, sb_grant_i  in  1  arbiter handshake.
REQ-010 sb_begin_transaction_o, sb_end_transaction_o, sb_data_valid_o, sb_read_n_write_o  out  1 each; sb_address_data_o  out  32; sb_byte_enables_o  out  4; sb_burst_size_o  out  8.
REQ-011 sb_address_data_i  in  32; sb_end_transaction_i, sb_data_valid_i, sb_busy_i, sb_error_i  in  1 each.

Function
REQ-012 States: IDLE, REQUEST, ADDRESS, WRITE, WEND, READ, FINISH.
REQ-013 IDLE: cmd_ready_o=1; on cmd_valid_i, latch addr/rnw/len, go REQUEST next cycle.
REQ-014 REQUEST: sb_request_o=1 until FINISH; on sb_grant_i=1, go ADDRESS.
REQ-015 ADDRESS (one cycle): sb_begin_transaction_o=1, sb_address_data_o=latched address, sb_burst_size_o=len, sb_read_n_write_o=rnw, sb_byte_enables_o=4'hF; then go WRITE or READ.
REQ-016 All sb_*_o bus outputs other than sb_request_o SHALL be zero outside the cycles that drive them, because the bus is wired-OR.
REQ-017 WRITE: wr_ready_o = !sb_busy_i; a beat is transferred when wr_valid_i && !sb_busy_i, driving sb_data_valid_o=1 with sb_address_data_o=wr_data_i.
REQ-018 If wr_valid_i=0, the block SHALL stall with sb_data_valid_o=0; after beat len+1 it SHALL go WEND.
REQ-019 WEND (one cycle): sb_end_transaction_o=1, then go FINISH.
REQ-020 READ: each sb_data_valid_i SHALL produce rd_valid_o=1 with rd_data_o=sb_address_data_i in the same cycle (combinational, zero latency).
REQ-021 READ SHALL finish on sb_end_transaction_i; beats beyond len+1 SHALL be dropped; fewer than len+1 beats before the end SHALL set err_o.
REQ-022 sb_error_i in any of ADDRESS, WRITE, WEND or READ SHALL abort to FINISH with err_o=1 and no sb_end_transaction_o.
REQ-023 FINISH (one cycle): done_o=1, err_o valid, sb_request_o=0, then return to IDLE.
REQ-024 Simultaneous sb_end_transaction_i and sb_data_valid_i SHALL accept the beat first, then evaluate the count.
REQ-025 The beat counter is 9 bits wide, so len=255 (256 beats) SHALL not wrap.

Reset
REQ-026 On sb_reset_n_i=0, the state SHALL be IDLE immediately and every output SHALL be 0 except cmd_ready_o; cmd_ready_o SHALL be 0 during reset and 1 from the first cycle after release.
REQ-027 Reset mid-transaction SHALL drop the request without issuing sb_end_transaction_o.

Configuration
REQ-028 With SB_BURST_MASTER_TIMEOUT_EN defined, a counter SHALL clear on each slave beat, grant or end and count every other cycle in REQUEST, WRITE or READ; reaching TIMEOUT_CYCLES SHALL abort to FINISH with err_o=1.
REQ-029 Without SB_BURST_MASTER_TIMEOUT_EN, no watchdog logic SHALL exist and the block can wait indefinitely.

Structure
REQ-030 Package sb_pkg SHALL hold the state enum, SB_DATA_W=32, SB_BURST_W=8 and SB_BE_W=4.
REQ-031 The watchdog SHALL be the sub-module sb_watchdog, instantiated only under SB_BURST_MASTER_TIMEOUT_EN.

Verification
REQ-032 Write, len=0, addr 0x1000, data 0xDEADBEEF, slave sb_busy_i=1 for 5 cycles -> exactly one beat, data held until busy drops, then sb_end_transaction_o, then done_o=1 and err_o=0.
REQ-033 Read, len=3, slave returns 4 beats 0x0..0x3 and then end -> rd_valid_o pulses 4 times with matching data, then done_o=1 and err_o=0.
REQ-034 Read, len=3, slave gives 2 beats then end -> done_o=1 and err_o=1.
REQ-035 sb_error_i pulse during WRITE stall -> done_o=1, err_o=1, no sb_end_transaction_o.
REQ-036 TIMEOUT_EN with TIMEOUT_CYCLES=16 and grant never given -> done_o=1 and err_o=1 exactly 16 cycles after REQUEST entry.
REQ-037 sb_reset_n_i asserted mid-READ -> all outputs 0 in the same cycle; a new command after release completes normally.
